alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Second-generation parametrised ALU: single result slot with valid/ready handshake on input and output,
//  barrel shifts/rotates by a variable amount, status flags, and an iterative multiply (MUL) driven by an FSM.
//  Keeps operand isolation and enable-driven low-power holding. Sits between the issue logic and writeback.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 4 and a power of two
//  SHW    $clog2(WIDTH)  derived localparam; shift-amount width taken from b[SHW-1:0]
// PORTS
//  clk        in   1      single clock; all state updates on posedge clk
//  rst        in   1      synchronous, active-high reset
//  en         in   1      low-power enable; 0 freezes all state and forces in_ready=0
//  in_valid   in   1      op/a/b are valid
//  in_ready   out  1      block accepts the op this cycle (transfer = in_valid & in_ready)
//  op         in   4      opcode; see BEHAVIOUR
//  a, b       in   WIDTH  operands
//  out_valid  out  1      result/flags/err are valid
//  out_ready  in   1      consumer takes the result (transfer = out_valid & out_ready)
//  result     out  WIDTH  registered result
//  flags      out  4      {V,C,N,Z}, registered together with result
//  err        out  1      illegal opcode was executed
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=0, flags=0, err=0, mul counter=0.
//  Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT, 0110 INC, 0111 DEC,
//   1000 SHL, 1001 SHR (logical), 1010 ROL, 1011 ROR, 1100 SRA, 1101 MUL (low WIDTH bits), 1110 CMP (a-b;
//   sets flags, result=a-b), 1111 illegal -> result=0, flags=0, err=1. err=0 for every other op.
//  Operand isolation: b is forced to 0 inside the datapath for NOT/INC/DEC. Shifts use only b[SHW-1:0].
//  in_ready = en & (state==IDLE) & (!out_valid | out_ready). One output slot only; no skid buffer.
//  Single-cycle ops: accepted in cycle N -> out_valid=1 with result in cycle N+1.
//  out_valid clears on an output transfer unless a new result loads in the same cycle (load wins).
//  result/flags/err change only on a load; they are stable while out_valid=1 and out_ready=0.
//  FSM states: IDLE, MUL.
//   IDLE --accept MUL--> MUL: latch a, b; clear 2*WIDTH product accumulator; cnt=0.
//   MUL: each en=1 cycle, shift-add one multiplier bit; cnt++. On cnt==WIDTH-1 step, load result and
//   flags, out_valid=1, state->IDLE. Accepted in cycle N -> out_valid in cycle N+WIDTH (en held high).
//   en=0 in MUL pauses: cnt and accumulator hold; latency extends one cycle per en=0 cycle.
//   in_ready=0 throughout MUL; the output slot is guaranteed empty during MUL (in_ready rule above).
//  Flags: Z = (result==0); N = result[WIDTH-1].
//   C: ADD/INC carry-out; SUB/DEC/CMP borrow (1 when a < b unsigned); SHL/ROL last bit shifted out of MSB;
//   SHR/SRA/ROR last bit shifted out of LSB; shift amount 0 -> C=0, result=a;
//   MUL: C=1 iff upper WIDTH product bits nonzero; logic ops C=0.
//   V: signed overflow for ADD/SUB/INC/DEC/CMP; 0 for all other ops.
//  Widths: all arithmetic is modulo 2^WIDTH; the carry/borrow comes from a WIDTH+1-bit internal sum.
//  Simultaneous: output transfer and new accept in the same cycle is legal and back-to-back (throughput 1/cycle).
//  rst during MUL aborts: IDLE, out_valid=0 next cycle; the partial product is discarded.
//  en=0 while out_valid=1: outputs hold; out_ready is ignored (no transfer) until en=1.
// STRUCTURE
//  alu_pkg: opcode localparams (OP_ADD..OP_ILL), flag bit indices (FLG_Z=0,FLG_N=1,FLG_C=2,FLG_V=3),
//   FSM state encoding (ST_IDLE, ST_MUL).
//  Sub-module alu_mul_seq: iterative shift-add multiplier (start, en, busy, done, 2*WIDTH product).
//   It owns the counter and accumulator; alu_pipe owns the FSM, handshake, combinational ops and output regs.
// TESTING (WIDTH=16)
//  ADD a=FFFF b=0001, out_ready=1 -> next cycle result=0000, Z=1 C=1 V=0 N=0, err=0.
//  SUB a=8000 b=0001 -> 7FFF, V=1 C=0 N=0; CMP a=0003 b=0005 -> result=FFFE, C=1 N=1 Z=0.
//  ROR a=1234 b=0004 -> 4123, C=0; SHL a=8001 b=0001 -> 0002, C=1; SRA a=8000 b=000F -> FFFF.
//  MUL a=0100 b=0100 -> in_ready=0 for 16 cycles, out_valid at N+16, result=0000 C=1 Z=1; a=0003 b=0005 -> 000F C=0.
//  Back-pressure: out_ready=0 after ADD -> in_ready=0, result stable; out_ready=1 with in_valid=1 -> back-to-back.
//  en=0 for 3 cycles mid-MUL -> out_valid at N+19; rst at MUL cycle 5 -> out_valid=0, in_ready=1 after rst.
//  op=1111 -> result=0000, flags=0, err=1; the next legal op clears err.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_DEC = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_SRA = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_CMP = 4'hE;
    localparam logic [3:0] OP_ILL = 4'hF;

    // Bit positions inside the 4-bit {V,C,N,Z} flag vector.
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Ops that never look at b; b is zeroed for them so it cannot toggle the datapath.
    function automatic logic is_b_isolated(input logic [3:0] opcode);
        return (opcode == OP_NOT) || (opcode == OP_INC) || (opcode == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per enabled cycle.
// Bit 0 is consumed in the start cycle, so after start the unit stays busy for
// WIDTH-1 enabled cycles and pulses done (with the full product) on the last one.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [SHW-1:0]     cnt_reg;
    logic               busy_reg;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_step;

    // Partial product: the shifted multiplicand gated by the current multiplier bit.
    for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
        assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end

    assign acc_next  = acc_reg + addend;
    assign last_step = busy_reg & en & (cnt_reg == SHW'(WIDTH-1));
    assign busy      = busy_reg;
    assign done      = last_step;
    assign product   = acc_next;

    // Accumulator, operand shifters and bit counter; en=0 freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (en) begin
            if (start) begin
                mcand_reg  <= {{WIDTH{1'b0}}, a} << 1;
                mplier_reg <= b >> 1;
                acc_reg    <= {{WIDTH{1'b0}}, a & {WIDTH{b[0]}}};
                cnt_reg    <= SHW'(1);
                busy_reg   <= 1'b1;
            end else if (busy_reg) begin
                acc_reg    <= acc_next;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                if (last_step) begin
                    cnt_reg  <= '0;
                    busy_reg <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_reg + SHW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-slot ALU with valid/ready on both sides, barrel shifts/rotates,
// {V,C,N,Z} flags and an FSM-sequenced iterative multiply.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW:0] W_CNT = (SHW+1)'(WIDTH);

    state_t             state_reg, state_next;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [3:0]         flags_reg;
    logic               err_reg;

    logic               accept, out_xfer, mul_start, load_single;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   b_iso, opnd;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     sum_ext, diff_ext, shl_ext, shr_ext, sra_ext;
    logic [WIDTH-1:0]   rol_v, ror_v;
    logic               add_v, sub_v;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_ill;
    logic [WIDTH-1:0]   res_next;
    logic [3:0]         flags_next;
    logic               err_next;

    // Handshake: a new op is taken only in IDLE and only if the output slot is free or draining.
    assign in_ready    = en & (state_reg == ST_IDLE) & ~mul_busy & (~out_valid_reg | out_ready);
    assign accept      = in_valid & in_ready;
    assign out_xfer    = en & out_valid_reg & out_ready;
    assign mul_start   = accept & (op == OP_MUL);
    assign load_single = accept & (op != OP_MUL);

    // INC/DEC reuse the add/subtract path with a constant 1 in place of the isolated b.
    assign b_iso = is_b_isolated(op) ? '0 : b;
    assign opnd  = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b_iso;
    assign sh    = b_iso[SHW-1:0];

    assign sum_ext  = {1'b0, a} + {1'b0, opnd};
    assign diff_ext = {1'b0, a} - {1'b0, opnd};
    assign add_v    = (a[MSB] == opnd[MSB]) & (sum_ext[MSB] != a[MSB]);
    assign sub_v    = (a[MSB] != opnd[MSB]) & (diff_ext[MSB] != a[MSB]);

    // The extra bit beside a catches the last bit shifted out (0 when sh==0).
    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;
    assign sra_ext = $signed({a, 1'b0}) >>> sh;
    assign rol_v   = (a << sh) | (a >> (W_CNT - {1'b0, sh}));
    assign ror_v   = (a >> sh) | (a << (W_CNT - {1'b0, sh}));

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle ops: result plus carry/overflow before the common Z/N derivation.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = add_v;
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                alu_res = diff_ext[MSB:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = sub_v;
            end
            OP_AND: alu_res = a & b_iso;
            OP_OR:  alu_res = a | b_iso;
            OP_XOR: alu_res = a ^ b_iso;
            OP_NOT: alu_res = ~a;
            OP_SHL: begin
                alu_res = shl_ext[MSB:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            OP_SRA: begin
                alu_res = sra_ext[WIDTH:1];
                alu_c   = sra_ext[0];
            end
            OP_ROL: begin
                alu_res = rol_v;
                alu_c   = (sh != '0) & rol_v[0];
            end
            OP_ROR: begin
                alu_res = ror_v;
                alu_c   = (sh != '0) & ror_v[MSB];
            end
            OP_ILL: alu_ill = 1'b1;
            default: alu_res = '0;
        endcase
    end

    // Select what loads into the output slot: multiplier completion or a single-cycle op.
    always_comb begin
        res_next   = alu_res;
        flags_next = '0;
        err_next   = 1'b0;
        if (mul_done) begin
            res_next          = mul_product[MSB:0];
            flags_next[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
            flags_next[FLG_Z] = (mul_product[MSB:0] == '0);
            flags_next[FLG_N] = mul_product[MSB];
        end else if (alu_ill) begin
            res_next = '0;
            err_next = 1'b1;
        end else begin
            flags_next[FLG_V] = alu_v;
            flags_next[FLG_C] = alu_c;
            flags_next[FLG_N] = alu_res[MSB];
            flags_next[FLG_Z] = (alu_res == '0);
        end
    end

    // FSM next state: leave IDLE on an accepted MUL, return when the multiplier finishes.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register; held while en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else if (en) begin
            state_reg <= state_next;
        end
    end

    // Output slot: a load wins over a same-cycle drain; data only changes on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= '0;
            err_reg       <= 1'b0;
        end else if (en) begin
            if (load_single || mul_done) begin
                out_valid_reg <= 1'b1;
                result_reg    <= res_next;
                flags_reg     <= flags_next;
                err_reg       <= err_next;
            end else if (out_xfer) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign flags     = flags_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed vector table, hand-written
// handshake/MUL corner sequences and a randomized phase against a reference model.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, en, in_valid, in_ready, out_valid, out_ready, err;
    logic [3:0]   op, flags;
    logic [W-1:0] a, b, result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;
        logic        e;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic        e;
    } exp_t;

    vec_t tbl [0:23];
    exp_t q [$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: arithmetic straight from the opcode definitions, flags as {V,C,N,Z}.
    function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t   r;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint full = 0;
        int     s = int'(y[3:0]);
        logic   c = 1'b0;
        logic   v = 1'b0;
        logic [15:0] t = x;
        r.e = 1'b0;
        case (o)
            OP_ADD: begin full = ux + uy; c = full > 65535; v = (sx + sy > 32767) || (sx + sy < -32768); end
            OP_SUB, OP_CMP: begin full = ux - uy; c = ux < uy; v = (sx - sy > 32767) || (sx - sy < -32768); end
            OP_AND: full = longint'(x & y);
            OP_OR:  full = longint'(x | y);
            OP_XOR: full = longint'(x ^ y);
            OP_NOT: full = longint'(~x);
            OP_INC: begin full = ux + 1; c = full > 65535; v = sx + 1 > 32767; end
            OP_DEC: begin full = ux - 1; c = (ux == 0); v = sx - 1 < -32768; end
            OP_SHL: begin full = ux << s; c = (s != 0) && (((ux >> (16 - s)) & 1) == 1); end
            OP_SHR: begin full = ux >> s; c = (s != 0) && (((ux >> (s - 1)) & 1) == 1); end
            OP_SRA: begin full = sx >>> s; c = (s != 0) && (((ux >> (s - 1)) & 1) == 1); end
            OP_ROL: begin
                for (int k = 0; k < s; k++) begin c = t[15]; t = {t[14:0], t[15]}; end
                full = longint'(t);
            end
            OP_ROR: begin
                for (int k = 0; k < s; k++) begin c = t[0]; t = {t[0], t[15:1]}; end
                full = longint'(t);
            end
            OP_MUL: begin full = ux * uy; c = full > 65535; end
            default: begin
                r.res = '0; r.flg = '0; r.e = 1'b1;
                return r;
            end
        endcase
        r.res = full[15:0];
        r.flg = {v, c, r.res[15], r.res == 16'h0000};
        return r;
    endfunction

    // Present one op on the input side and hold it until the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("issue_ready", in_ready, 1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Cycles from accept to out_valid: 1 means the result is visible right after the accept edge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   hits;
        exp_t e;
        bit   exp_valid, exp_rdy, xfer, acc;
        int   mul_left;

        tbl[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'h5, 1'b0};
        tbl[1]  = '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 4'h8, 1'b0};
        tbl[2]  = '{OP_CMP, 16'h0003, 16'h0005, 16'hFFFE, 4'h6, 1'b0};
        tbl[3]  = '{OP_ROR, 16'h1234, 16'h0004, 16'h4123, 4'h0, 1'b0};
        tbl[4]  = '{OP_SHL, 16'h8001, 16'h0001, 16'h0002, 4'h4, 1'b0};
        tbl[5]  = '{OP_SRA, 16'h8000, 16'h000F, 16'hFFFF, 4'h2, 1'b0};
        tbl[6]  = '{OP_MUL, 16'h0100, 16'h0100, 16'h0000, 4'h5, 1'b0};
        tbl[7]  = '{OP_MUL, 16'h0003, 16'h0005, 16'h000F, 4'h0, 1'b0};
        tbl[8]  = '{OP_ILL, 16'hFFFF, 16'hFFFF, 16'h0000, 4'h0, 1'b1};
        tbl[9]  = '{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 4'h2, 1'b0};
        tbl[10] = '{OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 4'h2, 1'b0};
        tbl[11] = '{OP_INC, 16'hFFFF, 16'hFFFF, 16'h0000, 4'h5, 1'b0};
        tbl[12] = '{OP_DEC, 16'h8000, 16'h0005, 16'h7FFF, 4'h8, 1'b0};
        tbl[13] = '{OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 4'h6, 1'b0};
        tbl[14] = '{OP_SHR, 16'h8001, 16'h0011, 16'h4000, 4'h4, 1'b0};
        tbl[15] = '{OP_ROL, 16'h8001, 16'h0004, 16'h0018, 4'h0, 1'b0};
        tbl[16] = '{OP_SHL, 16'h1234, 16'h0010, 16'h1234, 4'h0, 1'b0};
        tbl[17] = '{OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF, 4'h2, 1'b0};
        tbl[18] = '{OP_OR,  16'h0000, 16'h0000, 16'h0000, 4'h1, 1'b0};
        tbl[19] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'hA, 1'b0};
        tbl[20] = '{OP_SRA, 16'h8000, 16'h0004, 16'hF800, 4'h2, 1'b0};
        tbl[21] = '{OP_ROR, 16'h0001, 16'h0001, 16'h8000, 4'h6, 1'b0};
        tbl[22] = '{OP_SUB, 16'h0005, 16'h0003, 16'h0002, 4'h0, 1'b0};
        tbl[23] = '{OP_INC, 16'h7FFF, 16'h0000, 16'h8000, 4'hA, 1'b0};

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, one result per op.
        for (int i = 0; i < 24; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_out(lat);
            check("vec_latency", lat, (tbl[i].op == OP_MUL) ? 16 : 1);
            check("vec_result", result, tbl[i].res);
            check("vec_flags", flags, tbl[i].flg);
            check("vec_err", err, tbl[i].e);
            $display("vec %0d op=%h a=%h b=%h -> result=%h flags=%h err=%0d lat=%0d",
                     i, tbl[i].op, tbl[i].a, tbl[i].b, result, flags, err, lat);
        end

        // MUL keeps in_ready low for the whole multiply.
        issue(OP_MUL, 16'h0100, 16'h0100);
        lat = 1; hits = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) hits++;
            @(negedge clk);
            lat++;
        end
        check("mul_busy_in_ready", hits, 0);
        check("mul_latency", lat, 16);
        check("mul_result", result, 16'h0000);
        check("mul_flags", flags, 4'h5);
        $display("mul 0100*0100 -> result=%h flags=%h lat=%0d", result, flags, lat);

        // Back-pressure then back-to-back transfer + accept.
        @(negedge clk);
        out_ready = 1'b0;
        issue(OP_ADD, 16'h0001, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", result, 16'h0003);
            @(negedge clk);
        end
        op = OP_SUB; a = 16'h0005; b = 16'h0003; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_out_valid", out_valid, 1);
        check("b2b_result", result, 16'h0002);
        @(negedge clk);
        check("b2b_drained", out_valid, 0);
        $display("backpressure add 0001+0002 held, then sub 0005-0003 back-to-back -> %h", 16'h0002);

        // en low for three cycles in the middle of a MUL, then en low while holding a result.
        issue(OP_MUL, 16'h0003, 16'h0005);
        lat = 1; hits = 0;
        while (!out_valid && lat < 100) begin
            en = (lat >= 5 && lat <= 7) ? 1'b0 : 1'b1;
            #1;
            if (!en && in_ready) hits++;
            @(negedge clk);
            lat++;
        end
        check("pause_in_ready", hits, 0);
        check("pause_latency", lat, 19);
        check("pause_result", result, 16'h000F);
        check("pause_flags", flags, 4'h0);
        en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_result", result, 16'h000F);
            check("hold_in_ready", in_ready, 0);
        end
        en = 1'b1;
        @(negedge clk);
        check("hold_release", out_valid, 0);
        $display("mul 0003*0005 with 3 paused cycles -> result=%h lat=%0d", result, lat);

        // Reset in MUL cycle 5 discards the multiply.
        issue(OP_MUL, 16'h0100, 16'h0100);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("abort_no_result", hits, 0);
        issue(OP_ADD, 16'h0002, 16'h0003);
        wait_out(lat);
        check("abort_recover", result, 16'h0005);
        $display("mul aborted by reset, then add 0002+0003 -> %h", result);
        @(negedge clk);

        // Randomized traffic with random en/in_valid/out_ready, scoreboarded against the model.
        exp_valid = 1'b0; mul_left = 0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            @(negedge clk);
            if (cyc < 400) begin
                en        = ($urandom_range(0, 9) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                in_valid  = $urandom_range(0, 1) == 1;
            end else begin
                en = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
            end
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            #1;
            exp_rdy = en && (mul_left == 0) && (!exp_valid || out_ready);
            check("rnd_in_ready", in_ready, exp_rdy);
            check("rnd_out_valid", out_valid, exp_valid);
            xfer = en && exp_valid && out_ready;
            acc  = in_valid && exp_rdy;
            if (xfer && q.size() > 0) begin
                e = q.pop_front();
                check("rnd_result", result, e.res);
                check("rnd_flags", flags, e.flg);
                check("rnd_err", err, e.e);
                $display("rnd cyc %0d: result=%h flags=%h err=%0d (want %h %h %0d)",
                         cyc, result, flags, err, e.res, e.flg, e.e);
            end
            if (en) begin
                if (xfer) exp_valid = 1'b0;
                if (mul_left == 1) exp_valid = 1'b1;
                if (mul_left > 0) mul_left--;
                if (acc) begin
                    q.push_back(model(op, a, b));
                    if (op == OP_MUL) mul_left = W - 1;
                    else exp_valid = 1'b1;
                end
            end
        end
        check("rnd_final_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
